data_cache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the MEMORY pipeline stage and a multi-cycle backing data memory. It replaces the single-cycle data memory port seen by the pipeline. Hits complete in the request cycle. Misses and all writes raise `stall` until the backing memory handshakes, so the pipeline holds its MEMORY-stage request stable.

---
 rtl/data_cache_if.sv | 31 +++
 rtl/data_cache.sv | 154 +++++++++++++++
 tb/tb_data_cache.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/data_cache_if.sv
// Pipeline-side and backing-memory-side bus bundles for the data cache.
// master drives the request; slave answers it.
interface data_cache_cpu_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0] A;
    logic                     RE;
    logic                     WE;
    logic [DATA_WIDTH-1:0]    WD;
    logic [DATA_WIDTH-1:0]    RD;
    logic                     stall;

    modport master (output A, RE, WE, WD, input RD, stall);
    modport slave  (input A, RE, WE, WD, output RD, stall);
endinterface

interface data_cache_mem_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     mem_req;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic                     mem_ready;
    logic [DATA_WIDTH-1:0]    mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ready, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ready, mem_rdata);
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line.
// Define DCACHE_STATS_EN to build the hit/miss statistics counters.
module data_cache #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SET_BITS      = 4
) (
    input  logic               clk,
    input  logic               rst,
    data_cache_cpu_if.slave    cpu,
    data_cache_mem_if.master   mem,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
);
    localparam int NUM_LINES = 1 << SET_BITS;
    localparam int TAG_WIDTH = ADDRESS_WIDTH - SET_BITS - 2;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } line_t;

    state_t                   state, stateNext;
    logic [NUM_LINES-1:0]     validQ;
    line_t                    lines [NUM_LINES];

    logic [SET_BITS-1:0]      reqIdx, fillIdx;
    logic [TAG_WIDTH-1:0]     reqTag, fillTag;
    logic                     hit;
    logic                     idleRead, idleWrite, fillDone, writeDone;
    logic [DATA_WIDTH-1:0]    rdData;
    logic                     stallC;

    logic                     memReqQ, memWeQ;
    logic [ADDRESS_WIDTH-1:0] memAddrQ;
    logic [DATA_WIDTH-1:0]    memWdataQ;

    logic                     unusedLowBits;
    assign unusedLowBits = ^{cpu.A[1:0], memAddrQ[1:0]};

    assign reqIdx  = cpu.A[SET_BITS+1:2];
    assign reqTag  = cpu.A[ADDRESS_WIDTH-1:SET_BITS+2];
    assign fillIdx = memAddrQ[SET_BITS+1:2];
    assign fillTag = memAddrQ[ADDRESS_WIDTH-1:SET_BITS+2];

    assign hit       = validQ[reqIdx] && (lines[reqIdx].tag == reqTag);
    assign idleWrite = (state == IDLE) && cpu.WE;
    assign idleRead  = (state == IDLE) && cpu.RE && !cpu.WE;
    assign fillDone  = (state == FILL) && mem.mem_ready;
    assign writeDone = (state == WRITE) && mem.mem_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        stallC    = 1'b0;
        rdData    = lines[reqIdx].data;
        case (state)
            IDLE: begin
                if (cpu.WE) begin
                    stallC    = 1'b1;
                    stateNext = WRITE;
                end else if (cpu.RE && !hit) begin
                    stallC    = 1'b1;
                    stateNext = FILL;
                end
            end
            FILL: begin
                stallC = !mem.mem_ready;
                if (mem.mem_ready) begin
                    rdData    = mem.mem_rdata;
                    stateNext = IDLE;
                end
            end
            WRITE: begin
                stallC = !mem.mem_ready;
                if (mem.mem_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        // Reset must never hold the pipeline or leak stale line data.
        if (rst) begin
            stallC    = 1'b0;
            rdData    = '0;
            stateNext = IDLE;
        end
    end

    assign cpu.stall = stallC;
    assign cpu.RD    = rdData;

    always_ff @(posedge clk) begin
        if (rst) begin
            memReqQ   <= 1'b0;
            memWeQ    <= 1'b0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
            validQ    <= '0;
        end else begin
            if (idleWrite) begin
                memReqQ   <= 1'b1;
                memWeQ    <= 1'b1;
                memAddrQ  <= cpu.A;
                memWdataQ <= cpu.WD;
            end else if (idleRead && !hit) begin
                memReqQ  <= 1'b1;
                memWeQ   <= 1'b0;
                memAddrQ <= cpu.A;
            end else if (fillDone || writeDone) begin
                memReqQ <= 1'b0;
            end
            if (fillDone) validQ[fillIdx] <= 1'b1;
        end
    end

    // Tag/data storage needs no reset: validQ gates every use of it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (idleWrite && hit) lines[reqIdx].data <= cpu.WD;
            if (fillDone)         lines[fillIdx] <= '{tag: fillTag, data: mem.mem_rdata};
        end
    end

    assign mem.mem_req   = memReqQ;
    assign mem.mem_we    = memWeQ;
    assign mem.mem_addr  = memAddrQ;
    assign mem.mem_wdata = memWdataQ;

`ifdef DCACHE_STATS_EN
    logic [31:0] hitCntQ, missCntQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            hitCntQ  <= '0;
            missCntQ <= '0;
        end else if (idleRead) begin
            if (hit) hitCntQ  <= hitCntQ + 32'd1;
            else     missCntQ <= missCntQ + 32'd1;
        end
    end

    assign hit_count  = hitCntQ;
    assign miss_count = missCntQ;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: scoreboarded reads against a backing-memory model.
module tb_data_cache;
    logic clk;
    logic rst;
    logic [31:0] hit_count, miss_count;

    data_cache_cpu_if cpu ();
    data_cache_mem_if mem ();

    data_cache dut (
        .clk        (clk),
        .rst        (rst),
        .cpu        (cpu),
        .mem        (mem),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

`ifdef DCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int cntHit  = 0;
    int cntMiss = 0;
    logic [31:0] wantHit, wantMiss;
    logic [31:0] memModel [logic [31:0]];
    logic [31:0] rdQ [$];

    assign wantHit  = STATS ? 32'(cntHit)  : 32'd0;
    assign wantMiss = STATS ? 32'(cntMiss) : 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic doRead(input logic [31:0] addr, input bit expHit, input int k, input string nm);
        logic [31:0] e;
        @(posedge clk); #1;
        cpu.A = addr; cpu.RE = 1'b1; cpu.WE = 1'b0;
        rdQ.push_back(memModel[addr]);
        #1;
        if (expHit) begin
            cntHit++;
            total++; if (cpu.stall !== 1'b0) begin bad++; $display("FAIL %s hit_stall got=%b want=0", nm, cpu.stall); end
            e = rdQ.pop_front();
            total++; if (cpu.RD !== e) begin bad++; $display("FAIL %s hit_rd got=%h want=%h", nm, cpu.RD, e); end
            @(posedge clk); #1;
            cpu.RE = 1'b0;
        end else begin
            cntMiss++;
            total++; if (cpu.stall !== 1'b1) begin bad++; $display("FAIL %s miss_stall got=%b want=1", nm, cpu.stall); end
            @(posedge clk); #1;
            total++; if ({mem.mem_req, mem.mem_we} !== 2'b10) begin bad++; $display("FAIL %s req_we got=%b want=10", nm, {mem.mem_req, mem.mem_we}); end
            total++; if (mem.mem_addr !== addr) begin bad++; $display("FAIL %s mem_addr got=%h want=%h", nm, mem.mem_addr, addr); end
            for (int i = 0; i < k; i++) begin
                #1;
                total++; if ({cpu.stall, mem.mem_req} !== 2'b11) begin bad++; $display("FAIL %s wait_stall_req got=%b want=11", nm, {cpu.stall, mem.mem_req}); end
                @(posedge clk); #1;
            end
            mem.mem_ready = 1'b1; mem.mem_rdata = memModel[addr];
            #1;
            total++; if (cpu.stall !== 1'b0) begin bad++; $display("FAIL %s ready_stall got=%b want=0", nm, cpu.stall); end
            e = rdQ.pop_front();
            total++; if (cpu.RD !== e) begin bad++; $display("FAIL %s fill_rd got=%h want=%h", nm, cpu.RD, e); end
            @(posedge clk); #1;
            mem.mem_ready = 1'b0; mem.mem_rdata = '0; cpu.RE = 1'b0;
            total++; if (mem.mem_req !== 1'b0) begin bad++; $display("FAIL %s req_clear got=%b want=0", nm, mem.mem_req); end
        end
    endtask

    task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input int k, input bit alsoRead, input string nm);
        @(posedge clk); #1;
        cpu.A = addr; cpu.WD = data; cpu.WE = 1'b1; cpu.RE = alsoRead;
        memModel[addr] = data;
        #1;
        total++; if (cpu.stall !== 1'b1) begin bad++; $display("FAIL %s wr_stall got=%b want=1", nm, cpu.stall); end
        @(posedge clk); #1;
        total++; if ({mem.mem_req, mem.mem_we} !== 2'b11) begin bad++; $display("FAIL %s wr_req_we got=%b want=11", nm, {mem.mem_req, mem.mem_we}); end
        total++; if (mem.mem_addr !== addr) begin bad++; $display("FAIL %s wr_addr got=%h want=%h", nm, mem.mem_addr, addr); end
        total++; if (mem.mem_wdata !== data) begin bad++; $display("FAIL %s wr_wdata got=%h want=%h", nm, mem.mem_wdata, data); end
        for (int i = 0; i < k; i++) begin
            #1;
            total++; if ({cpu.stall, mem.mem_req} !== 2'b11) begin bad++; $display("FAIL %s wr_wait got=%b want=11", nm, {cpu.stall, mem.mem_req}); end
            @(posedge clk); #1;
        end
        mem.mem_ready = 1'b1;
        #1;
        total++; if (cpu.stall !== 1'b0) begin bad++; $display("FAIL %s wr_ready_stall got=%b want=0", nm, cpu.stall); end
        @(posedge clk); #1;
        mem.mem_ready = 1'b0; cpu.WE = 1'b0; cpu.RE = 1'b0;
        total++; if (mem.mem_req !== 1'b0) begin bad++; $display("FAIL %s wr_req_clear got=%b want=0", nm, mem.mem_req); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu.A = 32'h40; cpu.RE = 1'b1; cpu.WE = 1'b0; cpu.WD = '0;
        mem.mem_ready = 1'b0; mem.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (cpu.stall !== 1'b0) begin bad++; $display("FAIL reset stall got=%b want=0", cpu.stall); end
        total++; if (cpu.RD !== 32'h0) begin bad++; $display("FAIL reset rd got=%h want=0", cpu.RD); end
        rst = 1'b0; cpu.RE = 1'b0;
        total++; if ({mem.mem_req, mem.mem_we} !== 2'b00) begin bad++; $display("FAIL reset req_we got=%b want=00", {mem.mem_req, mem.mem_we}); end
        total++; if ({mem.mem_addr, mem.mem_wdata} !== 64'h0) begin bad++; $display("FAIL reset addr_wdata got=%h want=0", {mem.mem_addr, mem.mem_wdata}); end
        total++; if ({hit_count, miss_count} !== 64'h0) begin bad++; $display("FAIL reset counters got=%h want=0", {hit_count, miss_count}); end
    endtask

    task automatic test_read_miss_hit();
        memModel[32'h40] = 32'hDEADBEEF;
        doRead(32'h40, 1'b0, 2, "miss40");
        doRead(32'h40, 1'b1, 0, "hit40");
        total++; if (hit_count !== wantHit) begin bad++; $display("FAIL stats1 hit_count got=%0d want=%0d", hit_count, wantHit); end
        total++; if (miss_count !== wantMiss) begin bad++; $display("FAIL stats1 miss_count got=%0d want=%0d", miss_count, wantMiss); end
    endtask

    task automatic test_evict();
        memModel[32'h80] = 32'h12345678;
        doRead(32'h80, 1'b0, 1, "miss80");
        doRead(32'h40, 1'b0, 0, "evict40");
        doRead(32'h80, 1'b0, 0, "refill80");
        total++; if (miss_count !== wantMiss) begin bad++; $display("FAIL evict miss_count got=%0d want=%0d", miss_count, wantMiss); end
    endtask

    task automatic test_write();
        doWrite(32'h80, 32'hCAFEF00D, 0, 1'b0, "wrhit80");
        doRead(32'h80, 1'b1, 0, "rdafterwr80");
        doWrite(32'hC4, 32'h11112222, 1, 1'b0, "wrmissC4");
        doRead(32'hC4, 1'b0, 0, "noallocC4");
    endtask

    task automatic test_write_priority();
        logic [31:0] h0, m0;
        doRead(32'h40, 1'b0, 0, "prep40");
        h0 = wantHit; m0 = wantMiss;
        doWrite(32'h40, 32'hA5A55A5A, 0, 1'b1, "wrre40");
        total++; if (hit_count !== h0) begin bad++; $display("FAIL prio hit_count got=%0d want=%0d", hit_count, h0); end
        total++; if (miss_count !== m0) begin bad++; $display("FAIL prio miss_count got=%0d want=%0d", miss_count, m0); end
        doRead(32'h40, 1'b1, 0, "rdafterwrre40");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int i = 0; i < 4; i++) begin
            a = 32'h200 + 32'(i * 4);
            memModel[a] = $urandom;
            doRead(a, 1'b0, i, "b2bmiss");
            doRead(a, 1'b1, 0, "b2bhit");
        end
        total++; if (hit_count !== wantHit) begin bad++; $display("FAIL b2b hit_count got=%0d want=%0d", hit_count, wantHit); end
        total++; if (miss_count !== wantMiss) begin bad++; $display("FAIL b2b miss_count got=%0d want=%0d", miss_count, wantMiss); end
    endtask

    task automatic test_reset_mid_fill();
        memModel[32'h100] = 32'h0BADF00D;
        @(posedge clk); #1;
        cpu.A = 32'h100; cpu.RE = 1'b1; cpu.WE = 1'b0;
        #1;
        total++; if (cpu.stall !== 1'b1) begin bad++; $display("FAIL midfill stall got=%b want=1", cpu.stall); end
        @(posedge clk); #1;
        total++; if (mem.mem_req !== 1'b1) begin bad++; $display("FAIL midfill req got=%b want=1", mem.mem_req); end
        rst = 1'b1;
        #1;
        total++; if ({cpu.stall, cpu.RD} !== 33'h0) begin bad++; $display("FAIL midfill rst_out got=%h want=0", {cpu.stall, cpu.RD}); end
        @(posedge clk); #1;
        rst = 1'b0; cpu.RE = 1'b0;
        cntHit = 0; cntMiss = 0;
        total++; if ({mem.mem_req, mem.mem_we} !== 2'b00) begin bad++; $display("FAIL midfill req_we got=%b want=00", {mem.mem_req, mem.mem_we}); end
        total++; if (mem.mem_addr !== 32'h0) begin bad++; $display("FAIL midfill addr got=%h want=0", mem.mem_addr); end
        total++; if ({hit_count, miss_count} !== 64'h0) begin bad++; $display("FAIL midfill counters got=%h want=0", {hit_count, miss_count}); end
        mem.mem_ready = 1'b1; mem.mem_rdata = 32'h77;
        #1;
        total++; if (cpu.stall !== 1'b0) begin bad++; $display("FAIL midfill late_ready_stall got=%b want=0", cpu.stall); end
        @(posedge clk); #1;
        mem.mem_ready = 1'b0; mem.mem_rdata = '0;
        total++; if (mem.mem_req !== 1'b0) begin bad++; $display("FAIL midfill late_ready_req got=%b want=0", mem.mem_req); end
        doRead(32'h204, 1'b0, 0, "postrst204");
        doRead(32'h100, 1'b0, 1, "postrst100");
        doRead(32'h100, 1'b1, 0, "postrsthit100");
        total++; if (hit_count !== wantHit) begin bad++; $display("FAIL midfill hit_count got=%0d want=%0d", hit_count, wantHit); end
        total++; if (miss_count !== wantMiss) begin bad++; $display("FAIL midfill miss_count got=%0d want=%0d", miss_count, wantMiss); end
    endtask

    initial begin
        test_reset();
        test_read_miss_hit();
        test_evict();
        test_write();
        test_write_priority();
        test_back_to_back();
        test_reset_mid_fill();
        total++; if (rdQ.size() != 0) begin bad++; $display("FAIL scoreboard leftover got=%0d want=0", rdQ.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
